// File: rtl/fir_coe_sched_pkg.sv
// Shared types and helpers for the FIR coefficient-bank scheduler.
package fir_coe_sched_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPrep,
    StStream,
    StGap,
    StLoad,
    StSettle
  } coe_state_e;

  // Width needed to index n items, never less than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fir_coe_bank_ram.sv
// Coefficient bank storage: one write port, one registered read port.
module fir_coe_bank_ram #(
  parameter int unsigned DEPTH  = 104,
  parameter int unsigned WIDTH  = 29,
  parameter int unsigned ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Array contents survive reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/fir_coe_sched.sv
// Coefficient-bank scheduler: streams a stored half-tap set into the FIR, commits it with
// coe_load and holds the FIR in bypass until the new coefficients have settled.
module fir_coe_sched
  import fir_coe_sched_pkg::*;
#(
  parameter int unsigned COE_NUM      = 51,
  parameter int unsigned COE_NUM_HALF = (COE_NUM + 1) / 2,
  parameter int unsigned COE_WDTH     = 29,
  parameter int unsigned NUM_SETS     = 4,
  parameter int unsigned SETTLE_CYC   = 32,
  parameter int unsigned SET_W        = clog2_min1(NUM_SETS),
  parameter int unsigned IDX_W        = clog2_min1(COE_NUM_HALF)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [SET_W-1:0]    wr_set,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [COE_WDTH-1:0] wr_data,
  output logic                wr_err,
  input  logic                sel_req,
  input  logic [SET_W-1:0]    sel_set,
  output logic                sel_err,
  output logic                busy,
  output logic                done,
  output logic [SET_W-1:0]    cur_set,
  input  logic                byp_user,
  output logic                coe_vld,
  output logic [COE_WDTH-1:0] coe_din,
  output logic                coe_sop,
  output logic                coe_load,
  output logic                bypass
);

  localparam int unsigned DEPTH  = NUM_SETS * COE_NUM_HALF;
  localparam int unsigned ADDR_W = clog2_min1(DEPTH);
  localparam int unsigned CNT_W  = clog2_min1(SETTLE_CYC);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(COE_NUM_HALF - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE_CYC - 1);

  coe_state_e       state_q;
  logic [SET_W-1:0] set_q;
  logic [SET_W-1:0] cur_set_q;
  logic [IDX_W-1:0] idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             wr_err_q;
  logic             sel_err_q;
  logic             vld_q;
  logic             sop_q;
  logic             load_q;

  logic              wr_ok;
  logic              sel_ok;
  logic              rd_en;
  logic [IDX_W-1:0]  rd_idx;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;

  // The set being streamed is write-protected for the whole reload.
  assign wr_ok = wr_en && (32'(wr_idx) < COE_NUM_HALF) && (32'(wr_set) < NUM_SETS) &&
                 !(busy_q && (wr_set == set_q));
  assign sel_ok = sel_req && (32'(sel_set) < NUM_SETS) && (state_q == StIdle);

  assign wr_addr = ADDR_W'(wr_set) * ADDR_W'(COE_NUM_HALF) + ADDR_W'(wr_idx);
  assign rd_addr = ADDR_W'(set_q) * ADDR_W'(COE_NUM_HALF) + ADDR_W'(rd_idx);

  // Reads run one word ahead of the word currently on coe_din.
  always_comb begin
    rd_en  = 1'b0;
    rd_idx = '0;
    if (state_q == StPrep) begin
      rd_en = 1'b1;
    end else if ((state_q == StStream) && (idx_q != LAST_IDX)) begin
      rd_en  = 1'b1;
      rd_idx = idx_q + IDX_W'(1);
    end
  end

  fir_coe_bank_ram #(
    .DEPTH  (DEPTH),
    .WIDTH  (COE_WDTH),
    .ADDR_W (ADDR_W)
  ) u_bank_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_ok),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (coe_din)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      set_q     <= '0;
      cur_set_q <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_err_q  <= 1'b0;
      sel_err_q <= 1'b0;
      vld_q     <= 1'b0;
      sop_q     <= 1'b0;
      load_q    <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      sop_q     <= 1'b0;
      load_q    <= 1'b0;
      wr_err_q  <= wr_en && !wr_ok;
      sel_err_q <= sel_req && !sel_ok;
      case (state_q)
        StIdle: begin
          if (sel_ok) begin
            state_q <= StPrep;
            busy_q  <= 1'b1;
            set_q   <= sel_set;
            idx_q   <= '0;
          end
        end
        StPrep: begin
          state_q <= StStream;
          vld_q   <= 1'b1;
          sop_q   <= 1'b1;
        end
        StStream: begin
          if (idx_q == LAST_IDX) begin
            state_q <= StGap;
            vld_q   <= 1'b0;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        StGap: begin
          state_q <= StLoad;
          load_q  <= 1'b1;
        end
        StLoad: begin
          state_q <= StSettle;
          cnt_q   <= '0;
        end
        StSettle: begin
          if (cnt_q == LAST_CNT) begin
            state_q   <= StIdle;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            cur_set_q <= set_q;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign wr_err   = wr_err_q;
  assign sel_err  = sel_err_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign cur_set  = cur_set_q;
  assign coe_vld  = vld_q;
  assign coe_sop  = sop_q;
  assign coe_load = load_q;
  assign bypass   = byp_user | busy_q;

endmodule
